branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 104 ++++++++++
 tb/tb_branch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - conditional branch resolver with two-cycle flush sequencer
// Evaluates condition codes against ALU flags, computes the target and counts taken branches.
module branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic [2:0]  cond,
    input  logic [8:0]  offset,
    input  logic [15:0] pc_plus1,
    input  logic        V,
    input  logic        Z,
    input  logic        N,
    input  logic        stall,
    output logic        taken,
    output logic [15:0] target,
    output logic        flush,
    output logic        busy,
    output logic [15:0] taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLUSH1 = 2'd1,
        S_FLUSH2 = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_taken;
    logic [15:0] r_target;
    logic        r_flush;
    logic        r_busy;
    logic [15:0] r_taken_cnt;

    logic        w_accept;
    logic        w_cond_true;
    logic [15:0] w_offset_sext;
    logic [15:0] w_target;

    assign w_accept      = br_valid && !stall && (r_state == S_IDLE);
    assign w_offset_sext = {{7{offset[8]}}, offset};
    assign w_target      = pc_plus1 + w_offset_sext;

    always_comb begin
        w_cond_true = 1'b0;
        case (cond)
            3'b000:  w_cond_true = !Z;
            3'b001:  w_cond_true = Z;
            3'b010:  w_cond_true = !Z && !N;
            3'b011:  w_cond_true = N;
            3'b100:  w_cond_true = Z || (!Z && !N);
            3'b101:  w_cond_true = N || Z;
            3'b110:  w_cond_true = V;
            default: w_cond_true = 1'b1;
        endcase
    end

    // flush/busy are registered alongside the state so they track it exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_taken     <= 1'b0;
            r_target    <= 16'h0000;
            r_flush     <= 1'b0;
            r_busy      <= 1'b0;
            r_taken_cnt <= 16'h0000;
        end else begin
            r_taken <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_cond_true) begin
                        r_state  <= S_FLUSH1;
                        r_taken  <= 1'b1;
                        r_target <= w_target;
                        r_flush  <= 1'b1;
                        r_busy   <= 1'b1;
                        if (r_taken_cnt != 16'hFFFF) begin
                            r_taken_cnt <= r_taken_cnt + 16'd1;
                        end
                    end
                end
                S_FLUSH1: begin
                    r_state <= S_FLUSH2;
                end
                S_FLUSH2: begin
                    r_state <= S_IDLE;
                    r_flush <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_flush <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign taken     = r_taken;
    assign target    = r_target;
    assign flush     = r_flush;
    assign busy      = r_busy;
    assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed self-checking bench for branch_unit
// Inputs change just after the falling edge; outputs are sampled on the following falling edge.
module tb_branch_unit;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic [2:0]  cond;
    logic [8:0]  offset;
    logic [15:0] pc_plus1;
    logic        V, Z, N;
    logic        stall;
    logic        taken;
    logic [15:0] target;
    logic        flush;
    logic        busy;
    logic [15:0] taken_cnt;

    int total;
    int bad;

    branch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .br_valid  (br_valid),
        .cond      (cond),
        .offset    (offset),
        .pc_plus1  (pc_plus1),
        .V         (V),
        .Z         (Z),
        .N         (N),
        .stall     (stall),
        .taken     (taken),
        .target    (target),
        .flush     (flush),
        .busy      (busy),
        .taken_cnt (taken_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic model_cond(input logic [2:0] c, input logic v, input logic z, input logic n);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] model_target(input logic [15:0] pc, input logic [8:0] off);
        int s;
        s = int'(pc) + int'($signed(off));
        return 16'(s & 32'hFFFF);
    endfunction

    task automatic present(input logic [2:0] c, input logic [15:0] pc, input logic [8:0] off,
                           input logic v, input logic z, input logic n);
        br_valid = 1'b1;
        cond     = c;
        pc_plus1 = pc;
        offset   = off;
        V = v; Z = z; N = n;
    endtask

    logic [15:0] exp_cnt;
    logic [15:0] exp_tgt;
    logic        exp_tk;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; br_valid = 1'b0; cond = 3'd0; offset = 9'd0; pc_plus1 = 16'd0;
        V = 1'b0; Z = 1'b0; N = 1'b0; stall = 1'b0;
        exp_cnt = 16'd0;
        exp_tgt = 16'd0;

        // Asynchronous reset with no clock edge involved
        #2 rst = 1'b0;
        #1;
        check("rst_taken",  {15'd0, taken}, 16'd0);
        check("rst_flush",  {15'd0, flush}, 16'd0);
        check("rst_busy",   {15'd0, busy},  16'd0);
        check("rst_target", target,         16'h0000);
        check("rst_cnt",    taken_cnt,      16'h0000);
        cyc();
        rst = 1'b1;
        cyc();

        // EQ taken with two flush cycles
        present(3'b001, 16'h0010, 9'h005, 1'b0, 1'b1, 1'b0);
        cyc();
        br_valid = 1'b0;
        exp_cnt = 16'd1;
        check("eq_taken",  {15'd0, taken}, 16'd1);
        check("eq_target", target,         16'h0015);
        check("eq_flush1", {15'd0, flush}, 16'd1);
        check("eq_busy1",  {15'd0, busy},  16'd1);
        check("eq_cnt",    taken_cnt,      16'd1);
        cyc();
        check("eq_taken2", {15'd0, taken}, 16'd0);
        check("eq_flush2", {15'd0, flush}, 16'd1);
        check("eq_busy2",  {15'd0, busy},  16'd1);
        cyc();
        check("eq_flush3", {15'd0, flush}, 16'd0);
        check("eq_busy3",  {15'd0, busy},  16'd0);

        // Negative offset wrapping below zero
        present(3'b111, 16'h0002, 9'h1FC, 1'b0, 1'b0, 1'b0);
        cyc();
        br_valid = 1'b0;
        exp_cnt++;
        check("wrap_taken",  {15'd0, taken}, 16'd1);
        check("wrap_target", target,         16'hFFFE);
        cyc(); cyc();
        exp_tgt = 16'hFFFE;

        // All condition codes against all flag combinations
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                logic [15:0] pc;
                logic [8:0]  off;
                pc  = 16'h1000 + 16'(c * 16 + f);
                off = 9'(c * 7 + f * 3 + 1);
                present(3'(c), pc, off, f[2], f[1], f[0]);
                exp_tk = model_cond(3'(c), f[2], f[1], f[0]);
                cyc();
                br_valid = 1'b0;
                check($sformatf("sweep_taken_c%0d_f%0d", c, f), {15'd0, taken}, {15'd0, exp_tk});
                check($sformatf("sweep_flush_c%0d_f%0d", c, f), {15'd0, flush}, {15'd0, exp_tk});
                if (exp_tk) begin
                    exp_tgt = model_target(pc, off);
                    exp_cnt++;
                end
                check($sformatf("sweep_target_c%0d_f%0d", c, f), target, exp_tgt);
                if (exp_tk) begin
                    cyc(); cyc();
                end
            end
        end
        check("sweep_cnt", taken_cnt, exp_cnt);

        // br_valid held through the flush: only the first IDLE presentation counts
        present(3'b111, 16'h2000, 9'h010, 1'b0, 1'b0, 1'b0);
        cyc();
        present(3'b111, 16'h3000, 9'h020, 1'b0, 1'b0, 1'b0);
        exp_cnt++;
        check("mask_taken1",  {15'd0, taken}, 16'd1);
        check("mask_target1", target,         16'h2010);
        cyc();
        check("mask_taken2",  {15'd0, taken}, 16'd0);
        check("mask_target2", target,         16'h2010);
        check("mask_busy2",   {15'd0, busy},  16'd1);
        cyc();
        check("mask_taken3",  {15'd0, taken}, 16'd0);
        check("mask_busy3",   {15'd0, busy},  16'd0);
        check("mask_cnt3",    taken_cnt,      exp_cnt);
        cyc();
        br_valid = 1'b0;
        exp_cnt++;
        check("mask_taken4",  {15'd0, taken}, 16'd1);
        check("mask_target4", target,         16'h3020);
        check("mask_cnt4",    taken_cnt,      exp_cnt);
        cyc(); cyc();

        // Stall defers acceptance
        present(3'b111, 16'h4000, 9'h001, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        cyc();
        check("stall_taken1", {15'd0, taken}, 16'd0);
        check("stall_busy1",  {15'd0, busy},  16'd0);
        cyc();
        check("stall_taken2", {15'd0, taken}, 16'd0);
        stall = 1'b0;
        cyc();
        br_valid = 1'b0;
        exp_cnt++;
        check("stall_taken3",  {15'd0, taken}, 16'd1);
        check("stall_target3", target,         16'h4001);
        check("stall_cnt",     taken_cnt,      exp_cnt);

        // Reset in FLUSH1 clears everything immediately
        #2 rst = 1'b0;
        #1;
        check("midrst_taken",  {15'd0, taken}, 16'd0);
        check("midrst_flush",  {15'd0, flush}, 16'd0);
        check("midrst_busy",   {15'd0, busy},  16'd0);
        check("midrst_target", target,         16'h0000);
        check("midrst_cnt",    taken_cnt,      16'h0000);
        cyc();
        rst = 1'b1;
        cyc();
        check("postrst_flush1", {15'd0, flush}, 16'd0);
        cyc();
        check("postrst_flush2", {15'd0, flush}, 16'd0);
        check("postrst_busy2",  {15'd0, busy},  16'd0);

        // First edge after reset release accepts a branch
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        present(3'b000, 16'h0100, 9'h0FF, 1'b0, 1'b0, 1'b0);
        cyc();
        br_valid = 1'b0;
        check("relrst_taken",  {15'd0, taken}, 16'd1);
        check("relrst_target", target,         16'h01FF);
        check("relrst_cnt",    taken_cnt,      16'd1);
        cyc(); cyc();

        // Saturation of the taken counter
        force dut.r_taken_cnt = 16'hFFFE;
        cyc();
        release dut.r_taken_cnt;
        cyc();
        check("sat_preload", taken_cnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            present(3'b111, 16'h0000, 9'h001, 1'b0, 1'b0, 1'b0);
            cyc();
            br_valid = 1'b0;
            check($sformatf("sat_taken_%0d", k), {15'd0, taken}, 16'd1);
            check($sformatf("sat_cnt_%0d", k), taken_cnt, 16'hFFFF);
            cyc(); cyc();
        end
        check("sat_hold", taken_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
